// File: rtl/ebpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ebpc_pkg : shared types and widths for the EBPC decode path           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ebpc_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ZC_IDLE    = 2'd0,
        ZC_RUN     = 2'd1,
        ZC_DRAIN   = 2'd2,
        ZC_DISCARD = 2'd3
    } zrle_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/zrle_decode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zrle_decode_ctrl_if : command, word and bit handshakes of the ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface zrle_decode_ctrl_if
    import ebpc_pkg::*;
#(
    parameter int unsigned BIT_CNT_W  = 16,
    parameter int unsigned WORD_CNT_W = 12
);
    logic [BIT_CNT_W-1:0]  cmd_nbits_i;
    logic [WORD_CNT_W-1:0] cmd_nwords_i;
    logic                  cmd_vld_i;
    logic                  cmd_rdy_o;
    logic [DATA_W-1:0]     data_i;
    logic                  data_vld_i;
    logic                  data_rdy_o;
    logic [DATA_W-1:0]     dec_data_o;
    logic                  dec_vld_o;
    logic                  dec_rdy_i;
    logic                  dec_znz_i;
    logic                  dec_vld_i;
    logic                  dec_rdy_o;
    logic                  dec_flush_o;
    logic                  znz_o;
    logic                  vld_o;
    logic                  rdy_i;
    logic                  last_o;
    logic                  err_o;

    // Controller side
    modport slave (
        input  cmd_nbits_i, cmd_nwords_i, cmd_vld_i, data_i, data_vld_i,
               dec_rdy_i, dec_znz_i, dec_vld_i, rdy_i,
        output cmd_rdy_o, data_rdy_o, dec_data_o, dec_vld_o, dec_rdy_o,
               dec_flush_o, znz_o, vld_o, last_o, err_o
    );

    // Environment side
    modport master (
        output cmd_nbits_i, cmd_nwords_i, cmd_vld_i, data_i, data_vld_i,
               dec_rdy_i, dec_znz_i, dec_vld_i, rdy_i,
        input  cmd_rdy_o, data_rdy_o, dec_data_o, dec_vld_o, dec_rdy_o,
               dec_flush_o, znz_o, vld_o, last_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/ebpc_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ebpc_down_counter : loadable down counter that saturates at zero      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ebpc_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             is_one_o,
    output logic             is_zero_o
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign is_one_o  = (cnt_q == WIDTH'(1));
    assign is_zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/zrle_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zrle_decode_ctrl : per-transmission word admission and bit sequencing |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module zrle_decode_ctrl
    import ebpc_pkg::*;
#(
    parameter int unsigned BIT_CNT_W  = 16,
    parameter int unsigned WORD_CNT_W = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    zrle_decode_ctrl_if.slave  bus
);
    zrle_ctrl_state_t state_q, state_d;
    logic bits_one, bits_zero, words_one, words_zero;
    logic cmd_load, bit_hs, word_hs, final_bit, err_set, err_clr, err_q;

    ebpc_down_counter #(.WIDTH(BIT_CNT_W)) u_bits_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cmd_load),
        .load_val_i (bus.cmd_nbits_i),
        .en_i       (bit_hs),
        .is_one_o   (bits_one),
        .is_zero_o  (bits_zero)
    );

    ebpc_down_counter #(.WIDTH(WORD_CNT_W)) u_words_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cmd_load),
        .load_val_i (bus.cmd_nwords_i),
        .en_i       (word_hs),
        .is_one_o   (words_one),
        .is_zero_o  (words_zero)
    );

    assign bus.dec_data_o = bus.data_i;
    assign bus.err_o      = err_q;

    always_comb begin
        state_d         = state_q;
        bus.cmd_rdy_o   = 1'b0;
        bus.data_rdy_o  = 1'b0;
        bus.dec_vld_o   = 1'b0;
        bus.dec_rdy_o   = 1'b0;
        bus.dec_flush_o = 1'b0;
        bus.znz_o       = 1'b0;
        bus.vld_o       = 1'b0;
        bus.last_o      = 1'b0;
        cmd_load        = 1'b0;
        bit_hs          = 1'b0;
        word_hs         = 1'b0;
        final_bit       = 1'b0;
        err_set         = 1'b0;
        err_clr         = 1'b0;

        unique case (state_q)
            ZC_IDLE: begin
                bus.cmd_rdy_o = 1'b1;
                if (bus.cmd_vld_i) begin
                    cmd_load = 1'b1;
                    err_clr  = 1'b1;
                    if (bus.cmd_nbits_i == '0)       state_d = ZC_IDLE;
                    else if (bus.cmd_nwords_i == '0) state_d = ZC_DRAIN;
                    else                             state_d = ZC_RUN;
                end
            end
            ZC_RUN, ZC_DRAIN: begin
                // Bits never emitted once the bit budget is used up
                bus.vld_o     = bus.dec_vld_i & ~bits_zero;
                bus.znz_o     = bus.dec_znz_i;
                bus.dec_rdy_o = bus.rdy_i;
                bit_hs        = bus.vld_o & bus.rdy_i;
                final_bit     = bit_hs & bits_one;
                bus.last_o    = bus.vld_o & bits_one;
                bus.dec_flush_o = final_bit;
                if (state_q == ZC_RUN) begin
                    bus.data_rdy_o = bus.dec_rdy_i;
                    bus.dec_vld_o  = bus.data_vld_i & ~final_bit;
                    word_hs        = bus.data_vld_i & bus.dec_rdy_i;
                    if (word_hs && words_one) state_d = ZC_DRAIN;
                end
                if (final_bit) begin
                    if (words_zero || (word_hs && words_one)) begin
                        state_d = ZC_IDLE;
                    end else begin
                        err_set = 1'b1;
                        state_d = ZC_DISCARD;
                    end
                end
            end
            ZC_DISCARD: begin
                // Leftover words of a finished transmission are dropped
                bus.data_rdy_o = 1'b1;
                word_hs        = bus.data_vld_i;
                if (word_hs && words_one) state_d = ZC_IDLE;
            end
            default: state_d = ZC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ZC_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_clr)      err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end
endmodule
`default_nettype wire
